// File: rtl/tcp_vlg_tx_buf_mb.sv
// tcp_vlg_tx_buf_mb
// Multi-lane TCP transmit buffer. Payload bytes are stored at their sequence-number
// address across N interleaved banks so that a read starting at any byte offset
// can fetch N consecutive bytes per cycle. Remote ACKs that fall inside the
// [una, seq] window release space; out-of-window ACKs are dropped and flagged.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   init, isn                load seq/una with isn, abort any read
//   in_val, in_dat, in_rdy   byte write stream (written at address seq)
//   ack_val, ack, ack_err    remote ACK strobe/number, out-of-window pulse
//   rd_req, rd_addr, rd_len  read request (first sequence number, byte count)
//   rd_busy                  read stream in progress
//   out_val/dat/keep/last    read beats, N bytes per beat, lane 0 = lowest address
//   seq, una, used           write pointer, oldest unacked byte, bytes held
//   f, e, af                 full, empty, almost full
module tcp_vlg_tx_buf_mb #(
  parameter int D      = 16,
  parameter int W      = 8,
  parameter int N      = 4,
  parameter int AF_GAP = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [31:0]    isn,
  input  logic           in_val,
  input  logic [W-1:0]   in_dat,
  output logic           in_rdy,
  input  logic           ack_val,
  input  logic [31:0]    ack,
  output logic           ack_err,
  input  logic           rd_req,
  input  logic [31:0]    rd_addr,
  input  logic [D:0]     rd_len,
  output logic           rd_busy,
  output logic           out_val,
  output logic [N*W-1:0] out_dat,
  output logic [N-1:0]   out_keep,
  output logic           out_last,
  output logic [31:0]    seq,
  output logic [31:0]    una,
  output logic [D:0]     used,
  output logic           f,
  output logic           e,
  output logic           af
);

  localparam int LN    = (N > 1) ? $clog2(N) : 0;
  localparam int RW    = D - LN;
  localparam int ROWS  = 2 ** RW;
  localparam int DEPTH = 2 ** D;
  localparam int AF_TH = (DEPTH > AF_GAP) ? DEPTH - AF_GAP : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  logic [W-1:0]  mem [N][ROWS];
  logic [W-1:0]  ram_q [N];

  logic [31:0]   seq_q, seq_d, una_q, una_d;
  logic [D:0]    used_q, used_d;
  logic          e_q, e_d, f_q, f_d, af_q, af_d, in_rdy_q, in_rdy_d;
  logic          ack_err_q, ack_err_d;
  state_t        state_q, state_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [D:0]    rem_q, rem_d, take, req_len;
  logic          done_q, done_d;
  logic          out_val_q, out_val_d, out_last_q, out_last_d;
  logic [N-1:0]  out_keep_q, out_keep_d;
  logic [D-1:0]  rot_q, rot_d, off;
  logic [D-1:0]  wr_bank;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] rd_row [N];
  logic [31:0]   avail;
  logic          wr_en, ack_ok, in_win, issue;

  assign wr_en   = in_val & in_rdy_q & ~init;
  // Unsigned wrap arithmetic: distances from una place ack/rd_addr in the window.
  assign ack_ok  = (ack - una_q) <= (seq_q - una_q);
  assign in_win  = (rd_addr - una_q) < (seq_q - una_q);
  assign avail   = seq_q - rd_addr;
  assign issue   = (state_q == ISSUE) || ((state_q == STREAM) && !done_q);
  assign wr_bank = seq_q[D-1:0] & D'(N - 1);
  assign wr_row  = RW'(seq_q[D-1:0] >> LN);
  assign off     = ptr_q[D-1:0] & D'(N - 1);
  assign take    = (rem_q >= (D+1)'(N)) ? (D+1)'(N) : rem_q;

  always_comb begin
    req_len = '0;
    if (in_win) req_len = (avail < 32'(rd_len)) ? avail[D:0] : rd_len;
  end

  // Each bank fetches the row holding the byte that lands in it for this beat;
  // banks below the start offset belong to the next row (with wrap at 2**D).
  always_comb begin
    for (int b = 0; b < N; b++)
      rd_row[b] = RW'((ptr_q[D-1:0] + D'((b + N - int'(off)) % N)) >> LN);
  end

  always_comb begin
    seq_d     = seq_q;
    una_d     = una_q;
    ack_err_d = 1'b0;
    if (init) begin
      seq_d = isn;
      una_d = isn;
    end else begin
      if (wr_en) seq_d = seq_q + 32'd1;
      if (ack_val) begin
        if (ack_ok) una_d = ack;
        else        ack_err_d = 1'b1;
      end
    end
    // used never exceeds 2**D, so the low D+1 bits of the difference are exact.
    used_d   = seq_d[D:0] - una_d[D:0];
    e_d      = (used_d == '0);
    f_d      = used_d[D];
    in_rdy_d = ~used_d[D];
    af_d     = (int'(used_d) >= AF_TH);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    done_d     = done_q;
    rot_d      = rot_q;
    out_val_d  = 1'b0;
    out_keep_d = '0;
    out_last_d = 1'b0;
    if (issue) begin
      for (int i = 0; i < N; i++) out_keep_d[i] = ((D+1)'(i) < rem_q);
      out_val_d  = 1'b1;
      out_last_d = (rem_q <= (D+1)'(N));
      rot_d      = off;
      ptr_d      = ptr_q + 32'(N);
      rem_d      = rem_q - take;
      done_d     = (rem_q <= (D+1)'(N));
    end
    case (state_q)
      IDLE: if (rd_req) begin
        state_d = ISSUE;
        ptr_d   = rd_addr;
        rem_d   = req_len;
        done_d  = 1'b0;
      end
      ISSUE:   state_d = STREAM;
      STREAM:  if (out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (init) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      out_val_d  = 1'b0;
      out_keep_d = '0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      una_q      <= '0;
      used_q     <= '0;
      e_q        <= 1'b1;
      f_q        <= 1'b0;
      af_q       <= 1'b0;
      in_rdy_q   <= 1'b1;
      ack_err_q  <= 1'b0;
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b1;
      rot_q      <= '0;
      out_val_q  <= 1'b0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      una_q      <= una_d;
      used_q     <= used_d;
      e_q        <= e_d;
      f_q        <= f_d;
      af_q       <= af_d;
      in_rdy_q   <= in_rdy_d;
      ack_err_q  <= ack_err_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      rot_q      <= rot_d;
      out_val_q  <= out_val_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
    end
  end

  // Storage: unreset banked RAM with registered read data.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < N; b++)
        if (wr_bank == D'(b)) mem[b][wr_row] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (issue)
      for (int b = 0; b < N; b++) ram_q[b] <= mem[b][rd_row[b]];
  end

  // Output stage: lane i comes from bank (rot + i) mod N; idle and unkept lanes read zero.
  always_comb begin
    out_dat = '0;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < N; b++)
        if (out_val_q && out_keep_q[i] && (D'(b) == ((rot_q + D'(i)) & D'(N - 1))))
          out_dat[i*W +: W] = ram_q[b];
  end

  assign in_rdy   = in_rdy_q;
  assign ack_err  = ack_err_q;
  assign rd_busy  = (state_q != IDLE);
  assign out_val  = out_val_q;
  assign out_keep = out_keep_q;
  assign out_last = out_last_q;
  assign seq      = seq_q;
  assign una      = una_q;
  assign used     = used_q;
  assign f        = f_q;
  assign e        = e_q;
  assign af       = af_q;

endmodule
